// File: rtl/dircc_types_pkg.sv
// dircc_types_pkg: shared status types, register-map offsets and helpers for the status bank.
package dircc_types_pkg;
  typedef struct packed {
    logic [15:0] dircc_state;
    logic [15:0] dircc_state_extra;
  } dircc_status_t;
  localparam int DIRCC_OFF_STATE = 0;
  localparam int DIRCC_OFF_EXTRA = 1;
  localparam int DIRCC_OFF_USER = 2;
  localparam int DIRCC_OFF_IRQ_PENDING = 0;
  localparam int DIRCC_OFF_IRQ_ENABLE = 1;
  // Words per channel window: state + extra + user words, rounded up to a power of two.
  function automatic int dircc_ch_words(input int user_words);
    return 1 << $clog2(2 + user_words);
  endfunction
  function automatic logic [15:0] dircc_be_merge(input logic [15:0] old_v, input logic [15:0] new_v,
                                                 input logic [1:0] be);
    return {be[1] ? new_v[15:8] : old_v[15:8], be[0] ? new_v[7:0] : old_v[7:0]};
  endfunction
endpackage

// File: rtl/dircc_status_channel.sv
// dircc_status_channel: one device's state/extra/user_state storage, hardware-over-MM priority and change detect.
// DIRCC_STATUS_SHADOW_EN stages lower user words in a shadow committed by the top-word write.
module dircc_status_channel
  import dircc_types_pkg::*;
#(
  parameter int USER_STATE_WIDTH = 64,
  parameter int OFF_W = 3
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          mm_we_i,
  input  logic [OFF_W-1:0]              off_i,
  input  logic [15:0]                   wdata_i,
  input  logic [1:0]                    be_i,
  input  logic                          hw_valid_i,
  input  logic [31:0]                   hw_data_i,
  output logic [15:0]                   rdata_o,
  output logic                          chg_o,
  output logic [USER_STATE_WIDTH+31:0]  state_o
);
  localparam int UW = USER_STATE_WIDTH / 16;
  dircc_status_t st_q, st_d, hw;
  logic [USER_STATE_WIDTH-1:0] user_q, user_d;
  logic we_state, we_extra;
  assign hw = '{dircc_state: hw_data_i[15:0], dircc_state_extra: hw_data_i[31:16]};
  assign we_state = mm_we_i && off_i == OFF_W'(DIRCC_OFF_STATE);
  assign we_extra = mm_we_i && off_i == OFF_W'(DIRCC_OFF_EXTRA);
  assign chg_o = hw_valid_i && hw.dircc_state != st_q.dircc_state;
  always_comb begin
    st_d.dircc_state = hw_valid_i ? hw.dircc_state :
                       we_state ? dircc_be_merge(st_q.dircc_state, wdata_i, be_i) : st_q.dircc_state;
    st_d.dircc_state_extra = hw_valid_i ? hw.dircc_state_extra :
                             we_extra ? dircc_be_merge(st_q.dircc_state_extra, wdata_i, be_i) :
                             st_q.dircc_state_extra;
  end
`ifdef DIRCC_STATUS_SHADOW_EN
  logic [USER_STATE_WIDTH-1:0] shadow_q, shadow_d;
  // The top-word write publishes shadow plus itself in one edge, so read_state never tears.
  always_comb begin
    user_d = user_q;
    shadow_d = shadow_q;
    for (int j = 0; j < UW; j++)
      if (mm_we_i && off_i == OFF_W'(DIRCC_OFF_USER + j)) begin
        if (j == UW - 1) begin
          user_d = shadow_q;
          user_d[j*16 +: 16] = dircc_be_merge(user_q[j*16 +: 16], wdata_i, be_i);
        end else shadow_d[j*16 +: 16] = dircc_be_merge(shadow_q[j*16 +: 16], wdata_i, be_i);
      end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) shadow_q <= '0;
    else shadow_q <= shadow_d;
`else
  always_comb begin
    user_d = user_q;
    for (int j = 0; j < UW; j++)
      if (mm_we_i && off_i == OFF_W'(DIRCC_OFF_USER + j))
        user_d[j*16 +: 16] = dircc_be_merge(user_q[j*16 +: 16], wdata_i, be_i);
  end
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      st_q <= '0;
      user_q <= '0;
    end else begin
      st_q <= st_d;
      user_q <= user_d;
    end
  always_comb begin
    rdata_o = off_i == OFF_W'(DIRCC_OFF_STATE) ? st_q.dircc_state :
              off_i == OFF_W'(DIRCC_OFF_EXTRA) ? st_q.dircc_state_extra : '0;
    for (int j = 0; j < UW; j++)
      if (off_i == OFF_W'(DIRCC_OFF_USER + j)) rdata_o = user_q[j*16 +: 16];
  end
  assign state_o = {user_q, st_q.dircc_state_extra, st_q.dircc_state};
endmodule

// File: rtl/dircc_status_register_bank.sv
// dircc_status_register_bank: multi-channel dircc status registers behind a 16-bit Avalon-MM slave,
// with change-detect interrupts. Define DIRCC_STATUS_SHADOW_EN for atomic user_state commits.
module dircc_status_register_bank
  import dircc_types_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int USER_STATE_WIDTH = 64,
  parameter int ADDR_W = 8
) (
  input  logic                                         clk,
  input  logic                                         reset_n,
  input  logic [ADDR_W-1:0]                            status_address,
  input  logic                                         status_read,
  input  logic                                         status_write,
  input  logic [15:0]                                  status_writedata,
  input  logic [1:0]                                   status_byteenable,
  output logic [15:0]                                  status_readdata,
  output logic                                         status_readdatavalid,
  input  logic [NUM_CHANNELS*32-1:0]                   write_state,
  input  logic [NUM_CHANNELS-1:0]                      write_state_valid,
  output logic [NUM_CHANNELS*(32+USER_STATE_WIDTH)-1:0] read_state,
  output logic                                         irq
);
  localparam int CH_WORDS = dircc_ch_words(USER_STATE_WIDTH / 16);
  localparam int OFF_W = $clog2(CH_WORDS);
  localparam int CH_W = ADDR_W - 1 - OFF_W;
  localparam int RS_W = 32 + USER_STATE_WIDTH;
  logic [OFF_W-1:0] off;
  logic [CH_W-1:0] ch;
  logic addr_unused;
  logic [15:0] ch_rdata [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] chg, pending_q, pending_d, enable_q, enable_d, w1c;
  logic [15:0] rdata_d, rdata_q;
  logic rvalid_q, irq_q, gwe;
  assign {ch, off} = status_address[ADDR_W-1:1];
  assign addr_unused = status_address[0];
  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    dircc_status_channel #(
      .USER_STATE_WIDTH(USER_STATE_WIDTH),
      .OFF_W(OFF_W)
    ) u_ch (
      .clk(clk),
      .reset_n(reset_n),
      .mm_we_i(status_write && ch == CH_W'(c)),
      .off_i(off),
      .wdata_i(status_writedata),
      .be_i(status_byteenable),
      .hw_valid_i(write_state_valid[c]),
      .hw_data_i(write_state[c*32 +: 32]),
      .rdata_o(ch_rdata[c]),
      .chg_o(chg[c]),
      .state_o(read_state[c*RS_W +: RS_W])
    );
  end
  assign gwe = status_write && ch == CH_W'(NUM_CHANNELS);
  assign w1c = (gwe && off == OFF_W'(DIRCC_OFF_IRQ_PENDING)) ?
               NUM_CHANNELS'(dircc_be_merge(16'h0, status_writedata, status_byteenable)) : '0;
  // A fresh change outranks a W1C landing on the same bit.
  assign pending_d = (pending_q & ~w1c) | chg;
  assign enable_d = (gwe && off == OFF_W'(DIRCC_OFF_IRQ_ENABLE)) ?
                    NUM_CHANNELS'(dircc_be_merge(16'(enable_q), status_writedata, status_byteenable)) :
                    enable_q;
  always_comb begin
    rdata_d = (ch == CH_W'(NUM_CHANNELS)) ?
              (off == OFF_W'(DIRCC_OFF_IRQ_PENDING) ? 16'(pending_q) :
               off == OFF_W'(DIRCC_OFF_IRQ_ENABLE) ? 16'(enable_q) : '0) : '0;
    for (int c = 0; c < NUM_CHANNELS; c++)
      if (ch == CH_W'(c)) rdata_d = ch_rdata[c];
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pending_q <= '0;
      enable_q <= '0;
      rdata_q <= '0;
      rvalid_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      enable_q <= enable_d;
      rdata_q <= status_read ? rdata_d : rdata_q;
      rvalid_q <= status_read;
      irq_q <= |(pending_q & enable_q);
    end
  assign status_readdata = rdata_q;
  assign status_readdatavalid = rvalid_q;
  assign irq = irq_q;
endmodule
